// File: rtl/fp32_div_iter.sv
// fp32_div_iter: multi-cycle IEEE-754 single-precision divider (A / B).
// Radix-2 restoring mantissa divider producing one quotient bit per clock,
// followed by a single normalize / round-to-nearest-even / pack edge.
// Subnormal operands are flushed to zero and subnormal results flush to zero.
module fp32_div_iter #(
   parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        out_nv,
   output logic        out_dz
);

   localparam int Q_BITS = 26;
   localparam logic [4:0] LAST_STEP = 5'(Q_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_ROUND  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [23:0]        mb_q, mb_d;
   logic [25:0]        rem_q, rem_d;
   logic [25:0]        quo_q, quo_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               spec_q, spec_d;
   logic [31:0]        spec_res_q, spec_res_d;
   logic               spec_nv_q, spec_nv_d;
   logic               spec_dz_q, spec_dz_d;
   logic [31:0]        result_q, result_d;
   logic               nv_q, nv_d;
   logic               dz_q, dz_d;

   // Operand unpack and classification (only meaningful on the accept edge)
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        s_res;
   logic        za, zb, ia, ib, na, nb;
   logic        op_special;
   logic [31:0] op_spec_res;
   logic        op_spec_nv, op_spec_dz;

   assign ea    = A[30:23];
   assign eb    = B[30:23];
   assign fa    = A[22:0];
   assign fb    = B[22:0];
   assign s_res = A[31] ^ B[31];
   assign za    = (ea == 8'd0);
   assign zb    = (eb == 8'd0);
   assign ia    = (ea == 8'hFF) && (fa == 23'd0);
   assign ib    = (eb == 8'hFF) && (fb == 23'd0);
   assign na    = (ea == 8'hFF) && (fa != 23'd0);
   assign nb    = (eb == 8'hFF) && (fb != 23'd0);
   assign op_special = za | zb | ia | ib | na | nb;

   // Special-operand result table, resolved in priority order
   always_comb begin
      op_spec_res = {s_res, 31'd0};
      op_spec_nv  = 1'b0;
      op_spec_dz  = 1'b0;
      if (na || nb || (za && zb) || (ia && ib)) begin
         op_spec_res = CANON_NAN;
         op_spec_nv  = 1'b1;
      end else if (ia) begin
         op_spec_res = {s_res, 8'hFF, 23'd0};
      end else if (zb) begin
         op_spec_res = {s_res, 8'hFF, 23'd0};
         op_spec_dz  = 1'b1;
      end else begin
         op_spec_res = {s_res, 31'd0};
      end
   end

   // One restoring-division step on the current partial remainder
   logic        q_bit;
   logic [25:0] rem_sub;

   always_comb begin
      q_bit   = (rem_q >= {2'b00, mb_q});
      rem_sub = q_bit ? (rem_q - {2'b00, mb_q}) : rem_q;
   end

   // Normalize the 26-bit quotient, round to nearest even, and pack
   logic [22:0]       frac_pre;
   logic              guard, sticky, rnd_up;
   logic signed [9:0] exp_n, exp_r;
   logic [23:0]       frac_inc;
   logic [31:0]       rnd_res;

   always_comb begin
      if (quo_q[25]) begin
         frac_pre = quo_q[24:2];
         guard    = quo_q[1];
         sticky   = quo_q[0] | (rem_q != 26'd0);
         exp_n    = exp_q;
      end else begin
         frac_pre = quo_q[23:1];
         guard    = quo_q[0];
         sticky   = (rem_q != 26'd0);
         exp_n    = exp_q - 10'sd1;
      end
      rnd_up   = guard & (sticky | frac_pre[0]);
      frac_inc = {1'b0, frac_pre} + {23'd0, rnd_up};
      // A carry out of the fraction leaves frac_inc[22:0] at zero already
      exp_r    = exp_n + (frac_inc[23] ? 10'sd1 : 10'sd0);
      if (exp_r >= 10'sd255)
         rnd_res = {sign_q, 8'hFF, 23'd0};
      else if (exp_r <= 10'sd0)
         rnd_res = {sign_q, 31'd0};
      else
         rnd_res = {sign_q, exp_r[7:0], frac_inc[22:0]};
   end

   // Next-state and datapath control for the IDLE/DIVIDE/ROUND/DONE sequence
   always_comb begin
      state_d    = state_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      mb_d       = mb_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      spec_nv_d  = spec_nv_q;
      spec_dz_d  = spec_dz_q;
      result_d   = result_q;
      nv_d       = nv_q;
      dz_d       = dz_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sign_d     = s_res;
               exp_d      = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
               rem_d      = {2'b00, 1'b1, fa};
               mb_d       = {1'b1, fb};
               quo_d      = 26'd0;
               spec_d     = op_special;
               spec_res_d = op_spec_res;
               spec_nv_d  = op_spec_nv;
               spec_dz_d  = op_spec_dz;
               // Special operands spend a single DIVIDE edge so their
               // result appears two edges after accept.
               cnt_d      = op_special ? LAST_STEP : 5'd0;
               state_d    = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            quo_d = {quo_q[24:0], q_bit};
            rem_d = {rem_sub[24:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_STEP)
               state_d = S_ROUND;
         end
         S_ROUND: begin
            result_d = spec_q ? spec_res_q : rnd_res;
            nv_d     = spec_q & spec_nv_q;
            dz_d     = spec_q & spec_dz_q;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         sign_q     <= 1'b0;
         exp_q      <= 10'sd0;
         mb_q       <= 24'd0;
         rem_q      <= 26'd0;
         quo_q      <= 26'd0;
         cnt_q      <= 5'd0;
         spec_q     <= 1'b0;
         spec_res_q <= 32'd0;
         spec_nv_q  <= 1'b0;
         spec_dz_q  <= 1'b0;
         result_q   <= 32'd0;
         nv_q       <= 1'b0;
         dz_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         mb_q       <= mb_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         spec_nv_q  <= spec_nv_d;
         spec_dz_q  <= spec_dz_d;
         result_q   <= result_d;
         nv_q       <= nv_d;
         dz_q       <= dz_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign out_nv    = nv_q;
   assign out_dz    = dz_q;

endmodule

// File: tb/tb_fp32_div_iter.sv
// Self-checking bench for fp32_div_iter: directed vector table, handshake and
// reset corner sequences, and random operands against an arithmetic model.
module tb_fp32_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A, B;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        out_nv, out_dz;

   int nvec = 0;
   int nmis = 0;

   fp32_div_iter dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .out_nv   (out_nv),
      .out_dz   (out_dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        nv;
      logic        dz;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: exact integer quotient, then round-half-to-even on the
   // discarded bits with the true remainder breaking ties.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic nv,
                                   output logic dz, output int lat);
      int ea, eb, e, sh;
      logic s;
      logic za, zb, ia, ib, na, nb;
      longint unsigned ma, mb, q, rr, lowbits, half, mant;
      logic up;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      za = (ea == 0); zb = (eb == 0);
      ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
      na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
      nv = 1'b0; dz = 1'b0; r = 32'd0;
      if (za || zb || ia || ib || na || nb) begin
         lat = 2;
         if (na || nb || (za && zb) || (ia && ib)) begin r = 32'h7FC0_0000; nv = 1'b1; end
         else if (ia) r = {s, 8'hFF, 23'd0};
         else if (zb) begin r = {s, 8'hFF, 23'd0}; dz = 1'b1; end
         else r = {s, 31'd0};
         return;
      end
      lat = 27;
      ma = 64'(a[22:0]) + 64'h80_0000;
      mb = 64'(b[22:0]) + 64'h80_0000;
      q  = (ma << 25) / mb;
      rr = (ma << 25) % mb;
      e  = ea - eb + 127;
      if (q >= 64'h200_0000) sh = 2;
      else begin sh = 1; e = e - 1; end
      mant    = q >> sh;
      lowbits = q & ((64'd1 << sh) - 1);
      half    = 64'd1 << (sh - 1);
      up = (lowbits > half) || ((lowbits == half) && ((rr != 0) || mant[0]));
      if (up) mant = mant + 1;
      if (mant == 64'h100_0000) begin mant = mant >> 1; e = e + 1; end
      if (e >= 255) r = {s, 8'hFF, 23'd0};
      else if (e <= 0) r = {s, 31'd0};
      else r = {s, 8'(e), mant[22:0]};
   endfunction

   // Accept one operation, wait (bounded) for the result, but leave it in DONE
   task automatic start_wait(input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk);
      A = a; B = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = $urandom; B = $urandom;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic env, input logic edz, input int elat);
      int lat;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      start_wait(a, b, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      chk({tag, "_res"}, result, er);
      chk({tag, "_nv"}, 32'(out_nv), 32'(env));
      chk({tag, "_dz"}, 32'(out_dz), 32'(edz));
      release_out();
   endtask

   initial begin
      vec_t vt[$];
      logic [31:0] hold_res, ra, rb, er;
      logic env, edz;
      int elat, lat;

      vt.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 27});
      vt.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 27});
      vt.push_back('{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 1'b0, 1'b0, 27});
      vt.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, 2});
      vt.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, 2});
      vt.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 2});
      vt.push_back('{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 1'b0, 27});
      vt.push_back('{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 27});
      vt.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, 2});
      vt.push_back('{32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b0, 2});
      vt.push_back('{32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0, 2});
      vt.push_back('{32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 2});
      vt.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 27});
      vt.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2});
      vt.push_back('{32'hC1200000, 32'h40A00000, 32'hC0000000, 1'b0, 1'b0, 27});

      // Reset state, checked while reset is still asserted
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", result, 32'd0);
      chk("rst_nv", 32'(out_nv), 32'd0);
      chk("rst_dz", 32'(out_dz), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      foreach (vt[i])
         run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].res, vt[i].nv, vt[i].dz, vt[i].lat);

      // Back-pressure: result held for 10 cycles, in_valid ignored outside IDLE
      start_wait(32'h40C00000, 32'h40000000, lat);
      chk("bp_lat", 32'(lat), 32'd27);
      hold_res = 32'h40400000;
      in_valid = 1'b1; A = 32'h3F800000; B = 32'h40400000;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("bp_result", result, hold_res);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
      chk("bp_rel_out_valid", 32'(out_valid), 32'd0);
      run_check("bp_next", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 27);

      // Reset during DIVIDE aborts the operation
      @(negedge clk);
      A = 32'h3F800000; B = 32'h40400000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) chk("abort_no_result", 32'(out_valid), 32'd0);
      end
      run_check("abort_next", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 27);

      // Random operands, occasionally with zero/inf/NaN exponents
      for (int n = 0; n < 60; n++) begin
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 7) == 0) ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
         if ($urandom_range(0, 7) == 0) rb[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
         if ($urandom_range(0, 3) == 0) begin
            ra[30:23] = 8'($urandom_range(100, 154));
            rb[30:23] = 8'($urandom_range(100, 154));
         end
         ref_div(ra, rb, er, env, edz, elat);
         run_check($sformatf("rnd%0d_%h_%h", n, ra, rb), ra, rb, er, env, edz, elat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
